// File: rtl/shift_arbiter_if.sv
// Bundle of the two request ports, the result port and the grant counters
// of shift_arbiter. The slave modport is the arbiter's view; the master
// modport is the view of whoever drives requests and consumes results.
interface shift_arbiter_if #(
   parameter int CNT_W = 16
);
   logic          req0_valid;
   logic          req0_ready;
   logic [0:31]   req0_x;
   logic [0:4]    req0_shamt;
   logic          req0_arith;
   logic          req0_right;

   logic          req1_valid;
   logic          req1_ready;
   logic [0:31]   req1_x;
   logic [0:4]    req1_shamt;
   logic          req1_arith;
   logic          req1_right;

   logic          out_valid;
   logic          out_ready;
   logic [0:31]   out_z;
   logic          out_id;

   logic [0:CNT_W-1] gnt_cnt0;
   logic [0:CNT_W-1] gnt_cnt1;

   modport slave (
      input  req0_valid, req0_x, req0_shamt, req0_arith, req0_right,
      output req0_ready,
      input  req1_valid, req1_x, req1_shamt, req1_arith, req1_right,
      output req1_ready,
      output out_valid, out_z, out_id,
      input  out_ready,
      output gnt_cnt0, gnt_cnt1
   );

   modport master (
      output req0_valid, req0_x, req0_shamt, req0_arith, req0_right,
      input  req0_ready,
      output req1_valid, req1_x, req1_shamt, req1_arith, req1_right,
      input  req1_ready,
      input  out_valid, out_z, out_id,
      output out_ready,
      input  gnt_cnt0, gnt_cnt1
   );
endinterface

// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter in front of a single 32-bit barrel shifter.
// The winning request is shifted combinationally and captured in one output
// register that supports backpressure; the register also records which port
// produced the result. Saturating per-port grant counters track usage.
// Bit 0 of every data vector is the most significant bit.
module shift_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   shift_arbiter_if.slave  bus
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [0:31]      out_z_q, out_z_d;
   logic             out_id_q, out_id_d;
   logic             prio_q, prio_d;
   logic [0:CNT_W-1] gnt_cnt0_q, gnt_cnt0_d;
   logic [0:CNT_W-1] gnt_cnt1_q, gnt_cnt1_d;

   logic             slot_free;
   logic             gnt0, gnt1;
   logic             ready0, ready1;
   logic             acc0, acc1;
   logic [0:31]      sel_x;
   logic [4:0]       sel_amt;
   logic             sel_arith, sel_right;
   logic [0:31]      shift_res;

   // Logarithmic barrel shifter: five stages of 1/2/4/8/16 positions.
   // Right shifts fill from the top with the sign bit only when arith is
   // set; left shifts always zero-fill and ignore arith.
   function automatic logic [0:31] barrel_shift(
      input logic [0:31] x,
      input logic [4:0]  amt,
      input logic        arith,
      input logic        right
   );
      logic [0:31] v;
      logic [0:31] ones;
      logic        fill;
      v    = x;
      ones = '1;
      fill = right & arith & x[0];
      for (int s = 0; s < 5; s++) begin
         if (amt[s]) begin
            if (right) begin
               v = (v >> (1 << s)) | (fill ? ~(ones >> (1 << s)) : '0);
            end else begin
               v = v << (1 << s);
            end
         end
      end
      return v;
   endfunction

   // Arbitration, operand selection and next-state computation for the
   // output register, priority pointer and grant counters.
   always_comb begin
      slot_free = (state_q == ST_EMPTY) | bus.out_ready;

      gnt0 = bus.req0_valid & (~bus.req1_valid | ~prio_q);
      gnt1 = bus.req1_valid & (~bus.req0_valid |  prio_q);

      ready0 = rst_n & slot_free & gnt0;
      ready1 = rst_n & slot_free & gnt1;

      acc0 = bus.req0_valid & ready0;
      acc1 = bus.req1_valid & ready1;

      if (acc1) begin
         sel_x     = bus.req1_x;
         sel_amt   = bus.req1_shamt;
         sel_arith = bus.req1_arith;
         sel_right = bus.req1_right;
      end else begin
         sel_x     = bus.req0_x;
         sel_amt   = bus.req0_shamt;
         sel_arith = bus.req0_arith;
         sel_right = bus.req0_right;
      end

      shift_res = barrel_shift(sel_x, sel_amt, sel_arith, sel_right);

      state_d    = state_q;
      out_z_d    = out_z_q;
      out_id_d   = out_id_q;
      prio_d     = prio_q;
      gnt_cnt0_d = gnt_cnt0_q;
      gnt_cnt1_d = gnt_cnt1_q;

      if (acc0 | acc1) begin
         state_d  = ST_FULL;
         out_z_d  = shift_res;
         out_id_d = acc1;
         prio_d   = ~acc1;
      end else if ((state_q == ST_FULL) && bus.out_ready) begin
         state_d  = ST_EMPTY;
      end

      if (acc0 && (gnt_cnt0_q != '1)) begin
         gnt_cnt0_d = gnt_cnt0_q + 1'b1;
      end
      if (acc1 && (gnt_cnt1_q != '1)) begin
         gnt_cnt1_d = gnt_cnt1_q + 1'b1;
      end
   end

   // Output-register state machine plus priority pointer and counters;
   // reset drops any held result without an output handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         out_z_q    <= '0;
         out_id_q   <= 1'b0;
         prio_q     <= 1'b0;
         gnt_cnt0_q <= '0;
         gnt_cnt1_q <= '0;
      end else begin
         state_q    <= state_d;
         out_z_q    <= out_z_d;
         out_id_q   <= out_id_d;
         prio_q     <= prio_d;
         gnt_cnt0_q <= gnt_cnt0_d;
         gnt_cnt1_q <= gnt_cnt1_d;
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.out_valid  = (state_q == ST_FULL);
   assign bus.out_z      = out_z_q;
   assign bus.out_id     = out_id_q;
   assign bus.gnt_cnt0   = gnt_cnt0_q;
   assign bus.gnt_cnt1   = gnt_cnt1_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter. Stimulus pushes the hand-computed result
// of every expected accept into a scoreboard queue; an independent monitor
// pops and compares whenever the main instance completes an output
// handshake. A second instance with 4-bit counters covers saturation.
module tb_shift_arbiter;

   typedef struct packed {
      logic [31:0] z;
      logic        id;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   exp_t sbQ[$];

   shift_arbiter_if #(.CNT_W(16)) bus0 ();
   shift_arbiter_if #(.CNT_W(4))  bus1 ();

   shift_arbiter #(.CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   shift_arbiter #(.CNT_W(4)) dutSat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // Free-running 100 MHz style clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle of requests shortly after a rising edge, checks the
   // combinational readies and records the expected result of the accept.
   task automatic applyStimulus(
      input logic        v0,
      input logic        v1,
      input logic        oRdy,
      input logic [31:0] x0,
      input logic [4:0]  sh0,
      input logic        r0,
      input logic        a0,
      input logic [31:0] x1,
      input logic [4:0]  sh1,
      input logic        r1,
      input logic        a1,
      input logic        expR0,
      input logic        expR1,
      input logic [31:0] expZ
   );
      exp_t e;
      @(posedge clk);
      #2;
      bus0.req0_valid = v0;
      bus0.req0_x     = x0;
      bus0.req0_shamt = sh0;
      bus0.req0_right = r0;
      bus0.req0_arith = a0;
      bus0.req1_valid = v1;
      bus0.req1_x     = x1;
      bus0.req1_shamt = sh1;
      bus0.req1_right = r1;
      bus0.req1_arith = a1;
      bus0.out_ready  = oRdy;
      #1;
      checkOutput("req0Ready", {31'b0, bus0.req0_ready}, {31'b0, expR0});
      checkOutput("req1Ready", {31'b0, bus0.req1_ready}, {31'b0, expR1});
      if (expR0) begin
         e.z  = expZ;
         e.id = 1'b0;
         sbQ.push_back(e);
      end
      if (expR1) begin
         e.z  = expZ;
         e.id = 1'b1;
         sbQ.push_back(e);
      end
   endtask

   // Scoreboard monitor: every output handshake must match the oldest
   // outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus0.out_valid && bus0.out_ready) begin
         if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedOut got z=%h id=%0d expected no output", bus0.out_z, bus0.out_id);
         end else begin
            e = sbQ.pop_front();
            checkOutput("outZ", bus0.out_z, e.z);
            checkOutput("outId", {31'b0, bus0.out_id}, {31'b0, e.id});
         end
      end
   end

   localparam logic [31:0] X = 32'haa001100;

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus0.req0_valid = 0; bus0.req0_x = '0; bus0.req0_shamt = '0;
      bus0.req0_arith = 0; bus0.req0_right = 0;
      bus0.req1_valid = 0; bus0.req1_x = '0; bus0.req1_shamt = '0;
      bus0.req1_arith = 0; bus0.req1_right = 0;
      bus0.out_ready  = 0;
      bus1.req0_valid = 0; bus1.req0_x = X; bus1.req0_shamt = 5'd1;
      bus1.req0_arith = 0; bus1.req0_right = 0;
      bus1.req1_valid = 0; bus1.req1_x = '0; bus1.req1_shamt = '0;
      bus1.req1_arith = 0; bus1.req1_right = 0;
      bus1.out_ready  = 1;

      // Reset state, with a request pending to show ready stays low.
      #2;
      bus0.req0_valid = 1;
      #1;
      checkOutput("rstReady0", {31'b0, bus0.req0_ready}, 32'd0);
      checkOutput("rstOutValid", {31'b0, bus0.out_valid}, 32'd0);
      checkOutput("rstOutZ", bus0.out_z, 32'd0);
      checkOutput("rstOutId", {31'b0, bus0.out_id}, 32'd0);
      checkOutput("rstCnt0", {16'b0, bus0.gnt_cnt0}, 32'd0);
      checkOutput("rstCnt1", {16'b0, bus0.gnt_cnt1}, 32'd0);
      bus0.req0_valid = 0;
      rst_n = 1'b1;

      // Single left shift through port 0.
      applyStimulus(1, 0, 1, X, 5'd4, 0, 0, X, 5'd0, 0, 0, 1, 0, 32'ha0011000);

      // Right shifts through port 1.
      applyStimulus(0, 1, 1, X, 5'd0, 0, 0, X, 5'd1, 1, 1, 0, 1, 32'hd5000880);
      checkOutput("cnt0AfterFirst", {16'b0, bus0.gnt_cnt0}, 32'd1);
      applyStimulus(0, 1, 1, X, 5'd0, 0, 0, X, 5'd4, 1, 1, 0, 1, 32'hfaa00110);
      applyStimulus(0, 1, 1, X, 5'd0, 0, 0, X, 5'd4, 1, 0, 0, 1, 32'h0aa00110);

      // Contention: grants must alternate 0,1,0,1.
      applyStimulus(1, 1, 1, X, 5'd4, 0, 0, X, 5'd4, 1, 0, 1, 0, 32'ha0011000);
      applyStimulus(1, 1, 1, X, 5'd4, 0, 0, X, 5'd4, 1, 0, 0, 1, 32'h0aa00110);
      applyStimulus(1, 1, 1, X, 5'd4, 0, 0, X, 5'd4, 1, 0, 1, 0, 32'ha0011000);
      applyStimulus(1, 1, 1, X, 5'd4, 0, 0, X, 5'd4, 1, 0, 0, 1, 32'h0aa00110);

      // Port 0 alone, then backpressure with both ports waiting.
      applyStimulus(1, 0, 1, X, 5'd4, 0, 0, X, 5'd4, 1, 0, 1, 0, 32'ha0011000);
      checkOutput("cnt0AfterRR", {16'b0, bus0.gnt_cnt0}, 32'd3);
      checkOutput("cnt1AfterRR", {16'b0, bus0.gnt_cnt1}, 32'd5);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 0, X, 5'd4, 0, 0, X, 5'd4, 1, 0, 0, 0, 32'h0);
         checkOutput("holdValid", {31'b0, bus0.out_valid}, 32'd1);
         checkOutput("holdZ", bus0.out_z, 32'ha0011000);
      end

      // Backpressure released: one result per cycle, priority on port 1.
      applyStimulus(1, 1, 1, X, 5'd4, 0, 0, X, 5'd4, 1, 0, 0, 1, 32'h0aa00110);
      applyStimulus(1, 1, 1, X, 5'd4, 0, 0, X, 5'd4, 1, 0, 1, 0, 32'ha0011000);
      applyStimulus(0, 0, 0, X, 5'd0, 0, 0, X, 5'd0, 0, 0, 0, 0, 32'h0);
      checkOutput("preRstValid", {31'b0, bus0.out_valid}, 32'd1);

      // Asynchronous reset between edges while a result is held.
      #4;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncValid", {31'b0, bus0.out_valid}, 32'd0);
      checkOutput("asyncZ", bus0.out_z, 32'd0);
      checkOutput("asyncCnt0", {16'b0, bus0.gnt_cnt0}, 32'd0);
      checkOutput("asyncCnt1", {16'b0, bus0.gnt_cnt1}, 32'd0);
      sbQ.delete();
      #1;
      rst_n = 1'b1;

      // Priority pointer back at port 0 after reset.
      applyStimulus(1, 1, 1, X, 5'd4, 0, 0, X, 5'd4, 1, 0, 1, 0, 32'ha0011000);
      applyStimulus(0, 0, 1, X, 5'd0, 0, 0, X, 5'd0, 0, 0, 0, 0, 32'h0);
      checkOutput("postRstCnt0", {16'b0, bus0.gnt_cnt0}, 32'd1);
      checkOutput("postRstCnt1", {16'b0, bus0.gnt_cnt1}, 32'd0);
      applyStimulus(0, 0, 1, X, 5'd0, 0, 0, X, 5'd0, 0, 0, 0, 0, 32'h0);

      // Saturation on the 4-bit counter instance: 20 back-to-back accepts.
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #2;
         bus1.req0_valid = 1;
         if (i == 14) begin
            checkOutput("satMid", {28'b0, bus1.gnt_cnt0}, 32'he);
         end
      end
      @(posedge clk);
      #2;
      bus1.req0_valid = 0;
      checkOutput("satEnd", {28'b0, bus1.gnt_cnt0}, 32'hf);

      checkOutput("sbDrain", sbQ.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
